// File: rtl/npc_seq.sv
// Next-PC sequencer: PC+4 or ID redirect, holds redirects that arrive during a fetch stall.
// Latency: pc_next/pc_en combinational; an unstalled redirect lands at the same posedge.
// Backpressure: stall forces pc_en=0 and pc_next=pc_cur; a held redirect is applied on the first unstalled cycle.
module npc_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_cur,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_target,
    output logic [31:0]      pc_next,
    output logic             pc_en,
    output logic             redir_pending,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pend_tgt, pend_nxt;
    logic [31:0] tgt_a;
    logic        tgt_misaligned;

    // Targets are always word-aligned before use; the dropped bits only feed the error flag.
    assign tgt_a          = {redir_target[31:2], 2'b00};
    assign tgt_misaligned = redir_valid && (redir_target[1:0] != 2'b00);
    assign redir_pending  = (state == HELD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            pend_tgt     <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            pend_tgt <= pend_nxt;
            if (tgt_misaligned) begin
                misalign_err <= 1'b1;
            end
            if (pc_en) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        pc_next   = pc_cur;
        state_nxt = state;
        pend_nxt  = pend_tgt;
        if (reset) begin
            pc_next   = RESET_PC;
            state_nxt = RUN;
        end else begin
            case (state)
                HELD: begin
                    if (stall) begin
                        if (redir_valid) begin
                            pend_nxt = tgt_a;
                        end
                    end else begin
                        pc_en     = 1'b1;
                        pc_next   = redir_valid ? tgt_a : pend_tgt;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    if (stall) begin
                        if (redir_valid) begin
                            pend_nxt  = tgt_a;
                            state_nxt = HELD;
                        end
                    end else begin
                        pc_en     = 1'b1;
                        pc_next   = redir_valid ? tgt_a : pc_cur + 32'd4;
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

endmodule
